// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Results saturate to all nines when the input exceeds the decimal range.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);
    // state | meaning
    // IDLE  | waiting for start; bcd/overflow hold last result
    // CONV  | one shift-add-3 iteration per clock, BIN_W clocks total

    localparam int SW    = 4*(DIGITS+1);
    localparam int CNT_W = $clog2(BIN_W+1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t                state_q, state_d;
    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic [SW-1:0]         adj;
    logic [SW+BIN_W-1:0]   cat;

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS+1; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        cat = {adj, shift_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = ({{(64-BIN_W){1'b0}}, bin} > MAX_DEC);
                    state_d    = CONV;
                end
            end
            CONV: begin
                scratch_d = cat[SW+BIN_W-1:BIN_W];
                shift_d   = cat[BIN_W-1:0];
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // final iteration: publish result, saturating if out of range
                    bcd_d      = ovf_pend_q ? {DIGITS{4'h9}} : scratch_d[4*DIGITS-1:0];
                    overflow_d = ovf_pend_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == CONV);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed handshake cases plus random values
// checked against an arithmetic decimal reference.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done, overflow;
    logic [15:0] bcd;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic [15:0] prev;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int t;
        if (v > 9999) return 16'h9999;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues start with value, waits for done, checks result, latency and hold.
    task automatic run_conv(input int value, input logic [15:0] hold_exp,
                            input int pulse_at, output int l);
        bit ok;
        ok = 1'b1;
        l = -1;
        start = 1'b1;
        bin = 14'(value);
        @(posedge clk); #1;
        start = 1'b0;
        if (!busy || done) ok = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin
                l = c;
                break;
            end
            if (!busy || bcd !== hold_exp) ok = 1'b0;
            if (c == pulse_at) begin
                start = 1'b1;
                bin = 14'd77;
            end else if (c == pulse_at + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", l, 14);
        chk("busy_hold", {31'd0, ok}, 32'd1);
        chk("done_busy_excl", {31'd0, busy}, 32'd0);
        chk("bcd", {16'd0, bcd}, {16'd0, ref_bcd(value)});
        chk("overflow", {31'd0, overflow}, {31'd0, value > 9999});
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bcd", {16'd0, bcd}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv(0, 16'h0000, -1, lat);
        @(posedge clk); #1;
        chk("done_single", {31'd0, done}, 32'd0);
        run_conv(1234, 16'h0000, -1, lat);
        run_conv(9999, 16'h1234, -1, lat);
        run_conv(10000, 16'h9999, -1, lat);
        run_conv(16383, 16'h9999, -1, lat);
        @(posedge clk); #1;

        // start pulse while busy must be ignored
        run_conv(4321, 16'h9999, 5, lat);
        @(posedge clk); #1;
        chk("ignored_no_done", {31'd0, done}, 32'd0);
        chk("ignored_idle", {31'd0, busy}, 32'd0);

        // back-to-back: second start issued in the done cycle
        run_conv(42, 16'h4321, -1, lat);
        run_conv(808, 16'h0042, -1, lat);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a conversion
        run_conv(555, 16'h0808, -1, lat);
        @(posedge clk); #1;
        start = 1'b1;
        bin = 14'd900;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_bcd", {16'd0, bcd}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            bit quiet;
            quiet = 1'b1;
            for (int c = 0; c < 16; c++) begin
                @(posedge clk); #1;
                if (done || busy || bcd !== 16'h0000) quiet = 1'b0;
            end
            chk("arst_quiet", {31'd0, quiet}, 32'd1);
        end
        run_conv(5, 16'h0000, -1, lat);

        // random values, issued back-to-back
        prev = 16'h0005;
        for (int i = 0; i < 300; i++) begin
            int v;
            v = int'($urandom_range(16383, 0));
            if (i == 0) v = 9998;
            if (i == 1) v = 10001;
            run_conv(v, prev, -1, lat);
            prev = ref_bcd(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
